// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs,
// FSM states and the ALU idle encoding.
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;

    localparam logic [5:0] ALU_IDLE_OPC = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic is_alu_funct(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_MULT) || (fn == FN_DIV);
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two operand read ports, one debug read port and one
// write port. r0 always reads zero; every entry is cleared by reset.
module mips_regfile
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_q[wa] <= wd;
        end
    end

    assign ra_data  = (ra_addr  == 5'd0) ? 32'd0 : regs_q[ra_addr];
    assign rb_data  = (rb_addr  == 5'd0) ? 32'd0 : regs_q[rb_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer feeding an external
// registered ALU; runs from RESET_PC until it decodes a halt word.
module mips_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_funct,
    output logic [31:0] alu_busA,
    output logic [31:0] alu_busB,
    input  logic [31:0] alu_result,
    output logic        halted,
    output logic [31:0] instr_count,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        imem_req_q, imem_req_d;
    logic [5:0]  alu_opcode_q, alu_opcode_d;
    logic [5:0]  alu_funct_q, alu_funct_d;
    logic [31:0] alu_busa_q, alu_busa_d;
    logic [31:0] alu_busb_q, alu_busb_d;
    logic [4:0]  dest_q, dest_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;

    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rf_we;

    mips_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (ir_q[25:21]),
        .ra_data  (rs_data),
        .rb_addr  (ir_q[20:16]),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (dest_q),
        .wd       (alu_result)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        imem_req_d   = imem_req_q;
        alu_opcode_d = alu_opcode_q;
        alu_funct_d  = alu_funct_q;
        alu_busa_d   = alu_busa_q;
        alu_busb_d   = alu_busb_q;
        dest_d       = dest_q;
        halted_d     = halted_q;
        count_d      = count_q;
        rf_we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d       = RESET_PC;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Operand registers double as the ALU bus drivers, so the ALU
                // sees valid inputs from the very first EXEC cycle.
                if ((ir_q[31:26] == OPC_RTYPE) && is_alu_funct(ir_q[5:0])) begin
                    alu_opcode_d = ir_q[31:26];
                    alu_funct_d  = ir_q[5:0];
                    alu_busa_d   = rs_data;
                    alu_busb_d   = rt_data;
                    dest_d       = ir_q[15:11];
                    state_d      = S_EXEC;
                end else if (ir_q[31:26] == OPC_ADDI) begin
                    alu_opcode_d = ir_q[31:26];
                    alu_funct_d  = ir_q[5:0];
                    alu_busa_d   = rs_data;
                    alu_busb_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                    dest_d       = ir_q[20:16];
                    state_d      = S_EXEC;
                end else if (ir_q[31:26] == OPC_HALT) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d       = pc_q + 32'd4;
                    count_d    = count_q + 32'd1;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                rf_we        = (dest_q != 5'd0);
                pc_d         = pc_q + 32'd4;
                count_d      = count_q + 32'd1;
                imem_req_d   = 1'b1;
                alu_opcode_d = ALU_IDLE_OPC;
                alu_funct_d  = 6'd0;
                alu_busa_d   = 32'd0;
                alu_busb_d   = 32'd0;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= 32'd0;
            imem_req_q   <= 1'b0;
            alu_opcode_q <= ALU_IDLE_OPC;
            alu_funct_q  <= 6'd0;
            alu_busa_q   <= 32'd0;
            alu_busb_q   <= 32'd0;
            dest_q       <= 5'd0;
            halted_q     <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            imem_req_q   <= imem_req_d;
            alu_opcode_q <= alu_opcode_d;
            alu_funct_q  <= alu_funct_d;
            alu_busa_q   <= alu_busa_d;
            alu_busb_q   <= alu_busb_d;
            dest_q       <= dest_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
        end
    end

    // PC only moves on entry to FETCH, so it is the stable fetch address.
    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_funct   = alu_funct_q;
    assign alu_busA    = alu_busa_q;
    assign alu_busB    = alu_busb_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule
